// File: rtl/seg7_pkg.sv
// Shared glyph patterns and sizing helper for the seven-segment scan driver.
// Patterns are active-high a..g (bit0=a); the driver inverts them for common-anode pins.
package seg7_pkg;

  localparam logic [6:0] SEG_PAT_0 = 7'h3F;
  localparam logic [6:0] SEG_PAT_1 = 7'h06;
  localparam logic [6:0] SEG_PAT_2 = 7'h5B;
  localparam logic [6:0] SEG_PAT_3 = 7'h4F;
  localparam logic [6:0] SEG_PAT_4 = 7'h66;
  localparam logic [6:0] SEG_PAT_5 = 7'h6D;
  localparam logic [6:0] SEG_PAT_6 = 7'h7D;
  localparam logic [6:0] SEG_PAT_7 = 7'h07;
  localparam logic [6:0] SEG_PAT_8 = 7'h7F;
  localparam logic [6:0] SEG_PAT_9 = 7'h6F;
  localparam logic [6:0] SEG_PAT_A = 7'h77;
  localparam logic [6:0] SEG_PAT_B = 7'h7C;
  localparam logic [6:0] SEG_PAT_C = 7'h39;
  localparam logic [6:0] SEG_PAT_D = 7'h5E;
  localparam logic [6:0] SEG_PAT_E = 7'h79;
  localparam logic [6:0] SEG_PAT_F = 7'h71;

  // Active-low "all segments dark".
  localparam logic [6:0] SEG_OFF = 7'h7F;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seven_segment_glyph_rom.sv
// Nibble to active-low segment pattern; purely combinational, zero latency.
// Codes 10-15 render as hex letters only when HEX_MODE is set, otherwise dark.
module seven_segment_glyph_rom
  import seg7_pkg::*;
#(
  parameter int HEX_MODE = 0
) (
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  logic [6:0] pat;

  always_comb begin
    pat = 7'h00;
    case (nibble)
      4'h0: pat = SEG_PAT_0;
      4'h1: pat = SEG_PAT_1;
      4'h2: pat = SEG_PAT_2;
      4'h3: pat = SEG_PAT_3;
      4'h4: pat = SEG_PAT_4;
      4'h5: pat = SEG_PAT_5;
      4'h6: pat = SEG_PAT_6;
      4'h7: pat = SEG_PAT_7;
      4'h8: pat = SEG_PAT_8;
      4'h9: pat = SEG_PAT_9;
      4'hA: pat = (HEX_MODE != 0) ? SEG_PAT_A : 7'h00;
      4'hB: pat = (HEX_MODE != 0) ? SEG_PAT_B : 7'h00;
      4'hC: pat = (HEX_MODE != 0) ? SEG_PAT_C : 7'h00;
      4'hD: pat = (HEX_MODE != 0) ? SEG_PAT_D : 7'h00;
      4'hE: pat = (HEX_MODE != 0) ? SEG_PAT_E : 7'h00;
      4'hF: pat = (HEX_MODE != 0) ? SEG_PAT_F : 7'h00;
      default: pat = 7'h00;
    endcase
    seg_n = ~pat;
  end

endmodule

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed N-digit common-anode driver with LZ blanking, blink and dead time.
// All outputs registered; segment data latched at each slot start. Free-running, no backpressure.
module seven_segment_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 50000,
  parameter int DEAD_CYCLES  = 2,
  parameter int BLINK_FRAMES = 64,
  parameter int HEX_MODE     = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_blank,
  output logic [6:0]              segments,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic                    frame_done
);

  localparam int IW = idx_width(NUM_DIGITS);
  localparam int CW = idx_width(SLOT_CYCLES);
  localparam int FW = idx_width(BLINK_FRAMES);

  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] DEAD_LEN  = CW'(DEAD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FR_LAST   = FW'(BLINK_FRAMES - 1);

  logic [4*NUM_DIGITS-1:0] sh_digits;
  logic [NUM_DIGITS-1:0]   sh_dp, sh_blink;

  logic [CW-1:0] slot_cnt, cnt_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [FW-1:0] frame_cnt, frame_nxt;
  logic          phase_on, phase_nxt;
  logic          slot_wrap, frame_end;

  logic [3:0]            nib_arr [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  zero_above;
  logic [6:0]            glyph_n, seg_d;
  logic                  blink_off, dp_d;
  logic [NUM_DIGITS-1:0] an_d;

  // Every output register is loaded from the next-cycle counter view so that the
  // registered pins line up with the slot counter value they belong to.
  always_comb begin
    slot_wrap = (slot_cnt == SLOT_LAST);
    frame_end = slot_wrap && (idx == IDX_LAST);
    cnt_nxt   = slot_wrap ? '0 : slot_cnt + 1'b1;
    idx_nxt   = idx;
    if (slot_wrap) idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    frame_nxt = frame_cnt;
    phase_nxt = phase_on;
    if (frame_end) begin
      frame_nxt = (frame_cnt == FR_LAST) ? '0 : frame_cnt + 1'b1;
      if (frame_cnt == FR_LAST) phase_nxt = ~phase_on;
    end
  end

  // Digit i is a leading zero when it and every more-significant nibble are zero.
  always_comb begin
    zero_above = 1'b1;
    lz_mask    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib_arr[i] = sh_digits[4*i +: 4];
      zero_above = zero_above & (nib_arr[i] == 4'h0);
      lz_mask[i] = lz_blank && (i != 0) && zero_above;
    end
  end

  seven_segment_glyph_rom #(
    .HEX_MODE (HEX_MODE)
  ) u_glyph (
    .nibble (nib_arr[idx_nxt]),
    .seg_n  (glyph_n)
  );

  always_comb begin
    blink_off = !phase_nxt && sh_blink[idx_nxt];
    seg_d     = (blink_off || lz_mask[idx_nxt]) ? SEG_OFF : glyph_n;
    dp_d      = blink_off ? 1'b1 : ~sh_dp[idx_nxt];
    an_d      = '1;
    if (cnt_nxt >= DEAD_LEN) an_d[idx_nxt] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_digits  <= '0;
      sh_dp      <= '0;
      sh_blink   <= '0;
      slot_cnt   <= '0;
      idx        <= '0;
      frame_cnt  <= '0;
      phase_on   <= 1'b1;
      segments   <= SEG_OFF;
      dp         <= 1'b1;
      anodes     <= '1;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        sh_digits <= digits_in;
        sh_dp     <= dp_in;
        sh_blink  <= blink_mask;
      end
      slot_cnt   <= cnt_nxt;
      idx        <= idx_nxt;
      frame_cnt  <= frame_nxt;
      phase_on   <= phase_nxt;
      anodes     <= an_d;
      frame_done <= (cnt_nxt == SLOT_LAST) && (idx_nxt == IDX_LAST);
      if (cnt_nxt == '0) begin
        segments <= seg_d;
        dp       <= dp_d;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Randomized bench for seven_segment_scan_driver; two instances (HEX_MODE 0 and 1) share stimulus.
// The reference model works from cycle numbers since reset and the display rules directly.
module tb_seven_segment_scan_driver;

  localparam int N  = 4;
  localparam int S  = 8;
  localparam int D  = 2;
  localparam int BF = 2;

  logic        clk, rst_n, load, lz_blank;
  logic [15:0] digits_in;
  logic [3:0]  dp_in, blink_mask;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1, fd0, fd1;
  logic [3:0]  an0, an1;

  seven_segment_scan_driver #(
    .NUM_DIGITS(N), .SLOT_CYCLES(S), .DEAD_CYCLES(D), .BLINK_FRAMES(BF), .HEX_MODE(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .blink_mask(blink_mask), .lz_blank(lz_blank), .segments(seg0), .dp(dp0),
    .anodes(an0), .frame_done(fd0)
  );

  seven_segment_scan_driver #(
    .NUM_DIGITS(N), .SLOT_CYCLES(S), .DEAD_CYCLES(D), .BLINK_FRAMES(BF), .HEX_MODE(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .blink_mask(blink_mask), .lz_blank(lz_blank), .segments(seg1), .dp(dp1),
    .anodes(an1), .frame_done(fd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          k;
  logic [15:0] m_dig;
  logic [3:0]  m_dp, m_bl;
  logic [6:0]  m_seg [2];
  logic        m_dpo;
  logic [12:0] exp0, exp1, obs0, obs1;
  logic [12:0] blank_v;
  logic [6:0]  glyph_tab [16];

  function automatic logic [6:0] glyph(input logic [3:0] nib, input int hex);
    if (hex == 0 && nib > 4'd9) return 7'h00;
    return glyph_tab[nib];
  endfunction

  task automatic model_reset();
    k = 0;
    m_dig = '0; m_dp = '0; m_bl = '0;
    m_seg[0] = 7'h7F; m_seg[1] = 7'h7F; m_dpo = 1'b1;
  endtask

  task automatic sample();
    int cnt, idx;
    logic [3:0] an;
    logic fd;
    cnt = k % S;
    idx = (k / S) % N;
    an = 4'hF;
    if (cnt >= D) an[idx] = 1'b0;
    fd = (cnt == S - 1) && (idx == N - 1);
    exp0 = {m_seg[0], m_dpo, an, fd};
    exp1 = {m_seg[1], m_dpo, an, fd};
    obs0 = {seg0, dp0, an0, fd0};
    obs1 = {seg1, dp1, an1, fd1};
  endtask

  // One clock: the model reacts to the same pre-edge inputs the DUT sees.
  task automatic tick();
    int i, f;
    bit on, off, lzh;
    @(posedge clk);
    k++;
    if (k % S == 0) begin
      i   = (k / S) % N;
      f   = k / (S * N);
      on  = ((f / BF) % 2) == 0;
      off = !on && m_bl[i];
      lzh = lz_blank && (i > 0) && ((m_dig >> (4 * i)) == 16'h0);
      for (int h = 0; h < 2; h++)
        m_seg[h] = (off || lzh) ? 7'h7F : ~glyph(m_dig[4*i +: 4], h);
      m_dpo = off ? 1'b1 : ~m_dp[i];
    end
    if (load) begin
      m_dig = digits_in; m_dp = dp_in; m_bl = blink_mask;
    end
    #1;
    sample();
  endtask

  task automatic drive(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b, input logic lz);
    digits_in = d; dp_in = p; blink_mask = b; lz_blank = lz; load = 1'b1;
    tick();
    if ({obs0, obs1} !== {exp0, exp1}) begin
      miscompares++;
      $display("FAIL load_cycle k=%0d got %h/%h want %h/%h", k, obs0, obs1, exp0, exp1);
    end
    vectors++;
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0; blink_mask = '0; lz_blank = 1'b0;
    #3 rst_n = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if ({seg0, dp0, an0, fd0, seg1, dp1, an1, fd1} !== {blank_v, blank_v}) begin
        miscompares++;
        $display("FAIL reset_hold got %h/%h want %h", {seg0, dp0, an0, fd0}, {seg1, dp1, an1, fd1}, blank_v);
      end
      vectors++;
    end
    rst_n = 1'b1;
    model_reset();
    sample();
    if ({obs0, obs1} !== {exp0, exp1}) begin
      miscompares++;
      $display("FAIL reset_release got %h/%h want %h/%h", obs0, obs1, exp0, exp1);
    end
    vectors++;
  endtask

  task automatic test_count_pattern();
    drive(16'h1234, 4'h0, 4'h0, 1'b0);
    repeat (5 * S * N) begin
      tick();
      if ({obs0, obs1} !== {exp0, exp1}) begin
        miscompares++;
        $display("FAIL count_1234 k=%0d got %h/%h want %h/%h", k, obs0, obs1, exp0, exp1);
      end
      vectors++;
    end
  endtask

  task automatic test_leading_zero();
    logic [15:0] pats [3];
    pats[0] = 16'h0050; pats[1] = 16'h0000; pats[2] = 16'h0301;
    for (int p = 0; p < 3; p++) begin
      drive(pats[p], 4'b0100, 4'h0, 1'b1);
      repeat (2 * S * N) begin
        tick();
        if ({obs0, obs1} !== {exp0, exp1}) begin
          miscompares++;
          $display("FAIL lz_blank pat=%h k=%0d got %h/%h want %h/%h", pats[p], k, obs0, obs1, exp0, exp1);
        end
        vectors++;
      end
    end
    lz_blank = 1'b0;
  endtask

  task automatic test_hex_mode();
    drive(16'hBAF9, 4'b1010, 4'h0, 1'b0);
    repeat (2 * S * N) begin
      tick();
      if ({obs0, obs1} !== {exp0, exp1}) begin
        miscompares++;
        $display("FAIL hex_mode k=%0d got %h/%h want %h/%h", k, obs0, obs1, exp0, exp1);
      end
      vectors++;
    end
  endtask

  task automatic test_mid_slot_load();
    for (int r = 0; r < 12; r++) begin
      int wait_n;
      wait_n = 3 + int'($urandom_range(0, S - 1));
      repeat (wait_n) begin
        tick();
        if ({obs0, obs1} !== {exp0, exp1}) begin
          miscompares++;
          $display("FAIL mid_slot_load k=%0d got %h/%h want %h/%h", k, obs0, obs1, exp0, exp1);
        end
        vectors++;
      end
      drive(16'($urandom), 4'($urandom), 4'h0, 1'b0);
    end
  endtask

  task automatic test_reset_mid_slot();
    int guard;
    guard = 0;
    while ((k % (S * N)) != (3 * S + 3) && guard < 200) begin
      tick();
      guard++;
    end
    if ((k % (S * N)) != (3 * S + 3)) begin
      miscompares++;
      $display("FAIL reset_mid_slot_reach k=%0d want slot 3 cycle 3", k);
    end
    vectors++;
    rst_n = 1'b0;
    #1;
    if ({seg0, dp0, an0, fd0, seg1, dp1, an1, fd1} !== {blank_v, blank_v}) begin
      miscompares++;
      $display("FAIL reset_async got %h/%h want %h", {seg0, dp0, an0, fd0}, {seg1, dp1, an1, fd1}, blank_v);
    end
    vectors++;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    sample();
    if ({obs0, obs1} !== {exp0, exp1}) begin
      miscompares++;
      $display("FAIL reset_restart got %h/%h want %h/%h", obs0, obs1, exp0, exp1);
    end
    vectors++;
    repeat (S * N) begin
      tick();
      if ({obs0, obs1} !== {exp0, exp1}) begin
        miscompares++;
        $display("FAIL post_reset_scan k=%0d got %h/%h want %h/%h", k, obs0, obs1, exp0, exp1);
      end
      vectors++;
    end
  endtask

  task automatic test_blink();
    drive(16'h5678, 4'b0001, 4'b0001, 1'b0);
    repeat (7 * S * N) begin
      tick();
      if ({obs0, obs1} !== {exp0, exp1}) begin
        miscompares++;
        $display("FAIL blink k=%0d got %h/%h want %h/%h", k, obs0, obs1, exp0, exp1);
      end
      vectors++;
    end
  endtask

  task automatic test_random();
    repeat (800) begin
      logic [15:0] keep;
      keep = {{4{$urandom_range(0, 1) == 1}}, {4{$urandom_range(0, 1) == 1}},
              {4{$urandom_range(0, 1) == 1}}, {4{1'b1}}};
      digits_in  = 16'($urandom) & keep;
      dp_in      = 4'($urandom);
      blink_mask = 4'($urandom);
      load       = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 15) == 0) lz_blank = ~lz_blank;
      tick();
      if ({obs0, obs1} !== {exp0, exp1}) begin
        miscompares++;
        $display("FAIL random k=%0d got %h/%h want %h/%h", k, obs0, obs1, exp0, exp1);
      end
      vectors++;
    end
    load = 1'b0;
  endtask

  initial begin
    glyph_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    blank_v = {7'h7F, 1'b1, 4'hF, 1'b0};
    model_reset();
    test_reset();
    test_count_pattern();
    test_leading_zero();
    test_hex_mode();
    test_mid_slot_load();
    test_reset_mid_slot();
    test_blink();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
